// File: rtl/eth_pkt_dir_sel_pkg.sv
// Shared types and helpers for the packet direction selector.
package eth_pkt_dir_sel_pkg;

  localparam int unsigned MAC_W = 48;
  localparam logic [MAC_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_FWD,
    DS_DROP
  } dir_sel_state_t;

  // Group bit of the first DA octet marks a multicast (or broadcast) address.
  function automatic logic is_mcast(input logic [MAC_W-1:0] mac);
    return mac[40];
  endfunction

endpackage

// File: rtl/eth_pkt_dir_sel_if.sv
// Valid/ready packet stream with SOP/EOP framing.
interface eth_pkt_dir_sel_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned MOD_W  = 3,
  parameter int unsigned USER_W = 1
);

  logic              val;
  logic              ready;
  logic              sop;
  logic              eop;
  logic [MOD_W-1:0]  mod;
  logic [USER_W-1:0] tuser;
  logic [DATA_W-1:0] data;

  modport master (
    output val, sop, eop, mod, tuser, data,
    input  ready
  );

  modport slave (
    input  val, sop, eop, mod, tuser, data,
    output ready
  );

endinterface

// File: rtl/eth_pkt_dir_sel_classify.sv
// Combinational destination-MAC to direction-mask classifier.
module eth_pkt_dir_sel_classify
  import eth_pkt_dir_sel_pkg::*;
#(
  parameter int unsigned TX_DIR    = 2,
  parameter int unsigned LOCAL_DIR = 0
) (
  input  logic [MAC_W-1:0]  da,
  input  logic [MAC_W-1:0]  local_mac,
  input  logic [TX_DIR-1:0] en_mask,
  input  logic [TX_DIR-1:0] mcast_mask,
  input  logic [TX_DIR-1:0] dflt_mask,
  output logic [TX_DIR-1:0] mask_c
);

  localparam logic [TX_DIR-1:0] LOCAL_BIT = TX_DIR'(1) << LOCAL_DIR;

  // Broadcast beats multicast beats local hit beats default route.
  always_comb begin
    mask_c = '0;
    if (da == BCAST_MAC) begin
      mask_c = en_mask;
    end else if (is_mcast(da)) begin
      mask_c = mcast_mask & en_mask;
    end else if (da == local_mac) begin
      mask_c = LOCAL_BIT & en_mask;
    end else begin
      mask_c = dflt_mask & en_mask;
    end
  end

endmodule

// File: rtl/eth_pkt_dir_sel.sv
// Per-packet direction selector: classifies on SOP, registers the stream,
// holds a per-packet direction mask and drops packets with an empty mask.
module eth_pkt_dir_sel
  import eth_pkt_dir_sel_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned TX_DIR     = 2,
  parameter int unsigned LOCAL_DIR  = 0,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  eth_pkt_dir_sel_if.slave      pkt_i,
  eth_pkt_dir_sel_if.master     pkt_o,
  output logic [TX_DIR-1:0]     dir_mask_o,
  input  logic [TX_DIR-1:0]     en_mask_i,
  input  logic [TX_DIR-1:0]     mcast_mask_i,
  input  logic [TX_DIR-1:0]     dflt_mask_i,
  input  logic [MAC_W-1:0]      local_mac_i,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
  input  logic                  drop_cnt_clr_i,
  output logic                  orphan_o
);

  dir_sel_state_t    state;
  logic [TX_DIR-1:0] mask_c;
  logic              accept_c;
  logic              sop_fwd_c;
  logic              fwd_c;
  logic              drop_inc_c;

  eth_pkt_dir_sel_classify #(
    .TX_DIR    (TX_DIR),
    .LOCAL_DIR (LOCAL_DIR)
  ) u_classify (
    .da         (pkt_i.data[DATA_W-1 -: MAC_W]),
    .local_mac  (local_mac_i),
    .en_mask    (en_mask_i),
    .mcast_mask (mcast_mask_i),
    .dflt_mask  (dflt_mask_i),
    .mask_c     (mask_c)
  );

  // Single output stage: take a new word whenever it is empty or draining.
  assign pkt_i.ready = !pkt_o.val || pkt_o.ready;
  assign accept_c    = pkt_i.val && pkt_i.ready;
  assign sop_fwd_c   = accept_c && pkt_i.sop && (mask_c != '0);
  assign drop_inc_c  = accept_c && pkt_i.sop && (mask_c == '0);
  assign fwd_c       = sop_fwd_c || (accept_c && !pkt_i.sop && (state == DS_FWD));

  // Packet FSM, output register, latched mask, orphan pulse and drop counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= DS_IDLE;
      pkt_o.val   <= 1'b0;
      pkt_o.sop   <= 1'b0;
      pkt_o.eop   <= 1'b0;
      pkt_o.mod   <= '0;
      pkt_o.tuser <= '0;
      pkt_o.data  <= '0;
      dir_mask_o  <= '0;
      drop_cnt_o  <= '0;
      orphan_o    <= 1'b0;
    end else begin
      orphan_o <= 1'b0;

      if (pkt_o.ready) begin
        pkt_o.val <= 1'b0;
      end

      if (fwd_c) begin
        pkt_o.val   <= 1'b1;
        pkt_o.sop   <= pkt_i.sop;
        pkt_o.eop   <= pkt_i.eop;
        pkt_o.mod   <= pkt_i.mod;
        pkt_o.tuser <= pkt_i.tuser;
        pkt_o.data  <= pkt_i.data;
      end

      if (sop_fwd_c) begin
        dir_mask_o <= mask_c;
      end

      if (accept_c) begin
        if (pkt_i.sop) begin
          // A SOP inside a packet truncates it; the new packet is reclassified.
          if (state != DS_IDLE) begin
            orphan_o <= 1'b1;
          end
          if (pkt_i.eop) begin
            state <= DS_IDLE;
          end else if (mask_c != '0) begin
            state <= DS_FWD;
          end else begin
            state <= DS_DROP;
          end
        end else begin
          case (state)
            DS_IDLE: orphan_o <= 1'b1;
            DS_FWD,
            DS_DROP: begin
              if (pkt_i.eop) begin
                state <= DS_IDLE;
              end
            end
            default: state <= DS_IDLE;
          endcase
        end
      end

      if (drop_cnt_clr_i) begin
        drop_cnt_o <= '0;
      end else if (drop_inc_c && !(&drop_cnt_o)) begin
        drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
      end
    end
  end

endmodule
